output_bus_arbiter: RTL and testbench

//   Round-robin arbiter for the shared result bus between N output wrapper controllers.

---
 rtl/output_bus_arbiter_pkg.sv | 19 +
 rtl/output_bus_arbiter_if.sv | 27 ++
 rtl/output_bus_arbiter_picker.sv | 34 +++
 rtl/output_bus_arbiter.sv | 112 +++++++++++
 tb/tb_output_bus_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/output_bus_arbiter_pkg.sv
// Shared definitions for the result-bus arbiter: FSM encoding, default sizing
// and the width helper used wherever an index or counter width is derived.
package out_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } arb_state_e;

    localparam int DEF_N       = 4;
    localparam int DEF_TIMEOUT = 16;

    // clog2 that never returns 0, so single-entry vectors still get one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/output_bus_arbiter_if.sv
// Bundle between the output wrappers and the result-bus arbiter.
// master = the arbiter (owns the grant side), slave = the wrapper side.
interface output_bus_arbiter_if #(
    parameter int N = out_bus_pkg::DEF_N
) ();
    import out_bus_pkg::*;

    localparam int IDX_W = clog2_min1(N);

    logic [N-1:0]     req;
    logic [N-1:0]     done;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             busy;
    logic             timeout;

    modport master (
        input  req, done,
        output gnt, gnt_idx, busy, timeout
    );

    modport slave (
        output req, done,
        input  gnt, gnt_idx, busy, timeout
    );

endinterface

// File: rtl/output_bus_arbiter_picker.sv
// Round-robin priority picker: first requester at or after ptr, wrapping to 0.
// Purely combinational so any arbiter can wrap its own state around it.
module rr_priority_picker
    import out_bus_pkg::*;
#(
    parameter  int N     = DEF_N,
    localparam int IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] winner
);

    // Two passes: indices from ptr upward, then the wrapped part below ptr.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/output_bus_arbiter.sv
// Round-robin owner of the shared result bus. A grant is held until the owner
// reports done, drops its request, or exceeds TIMEOUT cycles; every release is
// followed by one bus-turnaround cycle with no grant.
module output_bus_arbiter
    import out_bus_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic                 clk,
    input logic                 rst,
    output_bus_arbiter_if.master bus
);

    localparam int IDX_W  = clog2_min1(N);
    localparam int HOLD_W = clog2_min1(TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = (TIMEOUT == 0) ? '0 : HOLD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);

    arb_state_e        state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              to_q, to_d;

    logic              found;
    logic [IDX_W-1:0]  winner;
    logic              rel_done, rel_drop, rel_time;

    rr_priority_picker #(.N(N)) u_picker (
        .req    (bus.req),
        .ptr    (ptr_q),
        .found  (found),
        .winner (winner)
    );

    // Next-state and next-output logic; only the owner's req/done are looked at.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        to_d    = 1'b0;

        rel_done = bus.done[idx_q];
        rel_drop = !bus.req[idx_q];
        rel_time = (TIMEOUT != 0) && (hold_q == HOLD_LAST);

        case (state_q)
            GRANT: begin
                if (rel_done || rel_drop || rel_time) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    // A completed or abandoned transfer is never reported as a timeout.
                    to_d    = rel_time && !rel_done && !rel_drop;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                // IDLE and RELEASE both arbitrate; RELEASE itself is the turnaround cycle.
                if (found) begin
                    state_d      = GRANT;
                    gnt_d        = '0;
                    gnt_d[winner] = 1'b1;
                    idx_d        = winner;
                    busy_d       = 1'b1;
                    hold_d       = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    // State and output registers; reset clears the grant without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = to_q;

endmodule

// File: tb/tb_output_bus_arbiter.sv
// Scoreboard bench for output_bus_arbiter (N=4, TIMEOUT=16). Stimulus pushes the
// expected bus events (grant change or timeout pulse) with the clock edge at which
// each must appear; the monitor pops and compares whenever the DUT shows one.
module tb_output_bus_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       busy;
        logic       to;
        int         at_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   edge_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    output_bus_arbiter_if #(.N(N)) bus ();

    output_bus_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock; rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Rising-edge counter shared by stimulus (for expectations) and monitor.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [3:0] gnt, input int idx,
                        input logic busy, input logic to, input int at_edge);
        exp_t e;
        e.tag     = tag;
        e.gnt     = gnt;
        e.idx     = 2'(idx);
        e.busy    = busy;
        e.to      = to;
        e.at_edge = at_edge;
        exp_q.push_back(e);
    endtask

    // Monitor: on the falling edge, any grant change or timeout pulse is an event.
    initial begin
        logic [3:0] prev;
        exp_t       e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (bus.gnt !== prev || bus.timeout !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got gnt=%b timeout=%b at edge %0d, expected no event",
                             bus.gnt, bus.timeout, edge_cnt);
                end else begin
                    e = exp_q.pop_front();
                    check({e.tag, "/gnt"},     bus.gnt,     e.gnt);
                    check({e.tag, "/busy"},    bus.busy,    e.busy);
                    check({e.tag, "/timeout"}, bus.timeout, e.to);
                    check({e.tag, "/edge"},    edge_cnt,    e.at_edge);
                    if (e.busy) check({e.tag, "/idx"}, bus.gnt_idx, e.idx);
                end
            end
            prev = bus.gnt;
        end
    end

    // Directed stimulus with hand-derived event timing.
    initial begin
        bus.req  = 4'b1111;
        bus.done = 4'b0000;
        rst      = 1'b1;

        // Reset holds everything low even with all requests raised.
        tick(3);
        check("rst_gnt",     bus.gnt,     4'b0000);
        check("rst_busy",    bus.busy,    1'b0);
        check("rst_timeout", bus.timeout, 1'b0);
        check("rst_idx",     bus.gnt_idx, 2'd0);
        rst = 1'b0;
        push("first_gnt0", 4'b0001, 0, 1'b1, 1'b0, edge_cnt + 1);
        tick(1);

        // Rotation 0,1,2,3,0 with done two cycles after each grant; one idle gap.
        for (int k = 0; k < 4; k++) begin
            push("rot_drop", 4'b0000, 0, 1'b0, 1'b0, edge_cnt + 2);
            push("rot_gnt", 4'(4'b0001 << ((k + 1) % 4)), (k + 1) % 4, 1'b1, 1'b0, edge_cnt + 3);
            tick(1);
            bus.done = 4'(4'b0001 << k);
            tick(1);
            bus.done = 4'b0000;
            tick(1);
        end

        // Owner 0 drops its request: next search starts at 1 and skips to 2.
        bus.req = 4'b0100;
        push("drop0_rel", 4'b0000, 0, 1'b0, 1'b0, edge_cnt + 1);
        push("skip_gnt2", 4'b0100, 2, 1'b1, 1'b0, edge_cnt + 2);
        tick(2);

        // Release 2 (ptr=3) with req=0101: search wraps to 0.
        bus.req  = 4'b0101;
        bus.done = 4'b0100;
        push("done2_rel", 4'b0000, 0, 1'b0, 1'b0, edge_cnt + 1);
        push("wrap_gnt0", 4'b0001, 0, 1'b1, 1'b0, edge_cnt + 2);
        tick(1);
        bus.done = 4'b0000;
        tick(1);

        // done[0]: ptr=1, req=0101 -> 2.
        bus.done = 4'b0001;
        push("done0_rel", 4'b0000, 0, 1'b0, 1'b0, edge_cnt + 1);
        push("skip_gnt2b", 4'b0100, 2, 1'b1, 1'b0, edge_cnt + 2);
        tick(1);
        bus.done = 4'b0000;
        tick(1);

        // Timeout: owner 2 never finishes; req[3] appearing does not preempt.
        bus.req = 4'b1100;
        push("to_rel",   4'b0000, 0, 1'b0, 1'b1, edge_cnt + 16);
        push("to_gnt3",  4'b1000, 3, 1'b1, 1'b0, edge_cnt + 17);
        tick(17);

        // Hand the bus to 1, then test done[3] (ignored) and done at the timeout cycle.
        bus.req = 4'b0010;
        push("drop3_rel", 4'b0000, 0, 1'b0, 1'b0, edge_cnt + 1);
        push("gnt1",      4'b0010, 1, 1'b1, 1'b0, edge_cnt + 2);
        tick(2);
        tick(3);
        bus.done = 4'b1000;
        tick(1);
        bus.done = 4'b0000;
        tick(11);
        bus.done = 4'b0010;
        push("done_vs_to_rel", 4'b0000, 0, 1'b0, 1'b0, edge_cnt + 1);
        push("regrant1",       4'b0010, 1, 1'b1, 1'b0, edge_cnt + 2);
        tick(1);
        bus.done = 4'b0000;
        tick(1);

        // Mid-grant reset while gnt=0100, then ptr is back to 0.
        bus.req = 4'b0100;
        push("drop1_rel", 4'b0000, 0, 1'b0, 1'b0, edge_cnt + 1);
        push("gnt2_pre_rst", 4'b0100, 2, 1'b1, 1'b0, edge_cnt + 2);
        tick(3);
        push("rst_drop", 4'b0000, 0, 1'b0, 1'b0, edge_cnt);
        rst = 1'b1;
        #1;
        check("midrst_gnt_now",  bus.gnt,  4'b0000);
        check("midrst_busy_now", bus.busy, 1'b0);
        bus.req = 4'b0110;
        tick(2);
        rst = 1'b0;
        push("post_rst_gnt1", 4'b0010, 1, 1'b1, 1'b0, edge_cnt + 1);
        tick(1);
        bus.req = 4'b0000;
        push("final_rel", 4'b0000, 0, 1'b0, 1'b0, edge_cnt + 1);
        tick(4);

        check("exp_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
